fp_result_packer: RTL and testbench
===================================

Name: fp_result_packer

Overview:
- Downstream stage of the FP adder tree. Drains 32-bit results from the adder's result FIFO through its standard-mode read port (dout, empty, rd_en).
- Packs the results little-endian into 256-bit AXI4-Stream beats and frames them into fixed-size packets with tkeep, tlast and a NetFPGA-style tuser.
- Output feeds the output-port arbiter so aggregated results can return to the network.

Parameters:
- FP_DATA_WIDTH, 32, width of one result word.
- C_M_AXIS_DATA_WIDTH, 256, output tdata width; LANES = C_M_AXIS_DATA_WIDTH/FP_DATA_WIDTH = 8.
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- WORDS_PER_PKT, 16, result words per packet; range 1..1023.
- DST_PORT, 8'h01, one-hot destination port written to tuser[31:24].
- FLUSH_CYCLES, 64, idle timeout; used only with the optional feature.

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- fifo_dout  in  FP_DATA_WIDTH  result FIFO read data; valid the cycle after rd_en (latency 1)
- fifo_empty  in  1  result FIFO empty
- fifo_rd_en  out  1  result FIFO read enable
- M_AXIS_tdata  out  C_M_AXIS_DATA_WIDTH  packed results
- M_AXIS_tkeep  out  C_M_AXIS_DATA_WIDTH/8  byte enables
- M_AXIS_tuser  out  C_M_AXIS_TUSER_WIDTH  metadata; meaningful on the first beat only
- M_AXIS_tvalid  out  1  beat valid
- M_AXIS_tready  in  1  downstream ready
- M_AXIS_tlast  out  1  last beat of packet
- pkt_sent  out  1  one-cycle pulse when a tlast beat handshakes

Behaviour:
- One clock (aclk). Reset srst is synchronous and active-high.
- Reset state:
  - fifo_rd_en=0, M_AXIS_tvalid=0, M_AXIS_tlast=0, pkt_sent=0.
  - tdata, tkeep and tuser = 0.
  - All counters = 0; FSM = FILL.
- Counters:
  - lane_cnt (0..LANES): words in the current beat.
  - pend (0/1): read issued, data due next cycle.
  - word_cnt (0..WORDS_PER_PKT): words taken in the current packet.
  - first_beat flag.
- Read rule: fifo_rd_en = (state==FILL) && !fifo_empty && (lane_cnt+pend < beat_target) && (word_cnt+pend < WORDS_PER_PKT).
  - beat_target = min(LANES, WORDS_PER_PKT - word_cnt at beat start).
  - Back-to-back reads are allowed, so throughput is one word per cycle while filling.
- Capture: in any cycle where pend=1, fifo_dout goes to lane lane_cnt, i.e. bits [32*lane_cnt+31 : 32*lane_cnt]. Then lane_cnt++ and word_cnt++. Unused lanes are 0.
- FSM:
  - FILL -> SEND when lane_cnt==beat_target and pend==0. Register tvalid=1.
    - tkeep: lowest 4*lane_cnt bits set.
    - tlast = (word_cnt==WORDS_PER_PKT).
    - tuser: if first_beat, tuser[15:0] = 4*WORDS_PER_PKT (bytes), [23:16]=0, [31:24]=DST_PORT, rest 0. Otherwise tuser=0.
  - SEND: tdata, tkeep, tuser and tlast stay stable while tvalid && !tready. No reads in SEND.
  - SEND, on tvalid && tready: tvalid=0 and lane_cnt=0.
    - If tlast: word_cnt=0, first_beat=1, pkt_sent=1 for one cycle.
    - Otherwise first_beat=0.
    - Return to FILL.
- Latency: first tvalid rises 2 cycles after the last word of a beat has rd_en asserted.
- Boundaries:
  - fifo_empty mid-beat: wait indefinitely in FILL. Partial beats are never emitted (unless the optional feature is enabled).
  - tready held low: FIFO backs up; upstream full is the adder's concern.
  - WORDS_PER_PKT < LANES: single-beat packets with tlast=1.
  - srst mid-operation: a pending read word and any partial beat/packet are discarded; outputs return to reset values the next cycle.

Optional Feature:
- Macro: FP_PACKER_FLUSH_EN.
- With it: an idle counter increments each FILL cycle with fifo_empty && pend==0 && word_cnt>0, and clears on any read.
  - At FLUSH_CYCLES, emit the current beat with tlast=1.
  - tuser[15:0] carries the actual byte count, but only if this is the first beat; otherwise tuser=0 as normal.
  - Then reset the packet counters.
- Without it: no counter; a partial packet waits for data forever.

Test Plan:
- WORDS_PER_PKT=16; push 16 words 0x3F800000+i; tready=1 -> two beats.
  - Beat 1: lane0=0x3F800000 ... lane7=0x3F800007, tkeep=0xFFFFFFFF, tuser[15:0]=64, tuser[31:24]=0x01, tlast=0.
  - Beat 2: lanes 0x3F800008..0x3F80000F, tuser=0, tlast=1.
  - pkt_sent pulses once.
- WORDS_PER_PKT=10; push 10 words -> beat 2 has tkeep=0x000000FF, lanes 2..7=0, tlast=1, tuser[15:0]=40 on beat 1.
- Hold tready=0 for 20 cycles with beat 1 valid -> tdata/tkeep/tuser stable, fifo_rd_en=0 throughout; on release, the beat transfers once.
- Empty FIFO gaps of 5 cycles between each word -> beats are identical to the back-to-back case; no duplicate or dropped words.
- Assert srst with 3 words of a beat captured and a read pending -> next cycle tvalid=0; the following 8 words form a fresh beat starting at lane0 with first-beat tuser.
- With FP_PACKER_FLUSH_EN, FLUSH_CYCLES=64: push 3 words then stop -> 64 idle cycles later, one beat with tkeep=0x00000FFF, tlast=1, tuser[15:0]=12.

Source files
------------

// File: rtl/fp_result_packer.sv
// Packs 32-bit adder-tree results into 256-bit AXI4-Stream beats framed as fixed-size packets.
// Define FP_PACKER_FLUSH_EN to emit a partial packet after FLUSH_CYCLES idle cycles.
module fp_result_packer #(
  parameter int         FP_DATA_WIDTH        = 32,
  parameter int         C_M_AXIS_DATA_WIDTH  = 256,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         WORDS_PER_PKT        = 16,
  parameter logic [7:0] DST_PORT             = 8'h01,
  parameter int         FLUSH_CYCLES         = 64
) (
  input  logic                              aclk,
  input  logic                              srst,
  input  logic [FP_DATA_WIDTH-1:0]          fifo_dout,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_tuser,
  output logic                              M_AXIS_tvalid,
  input  logic                              M_AXIS_tready,
  output logic                              M_AXIS_tlast,
  output logic                              pkt_sent
);
  localparam int LANES = C_M_AXIS_DATA_WIDTH / FP_DATA_WIDTH;
  localparam int BPL   = FP_DATA_WIDTH / 8;
  localparam int KW    = C_M_AXIS_DATA_WIDTH / 8;
  localparam int CW    = 12;
  localparam int LIW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] WPP_C   = CW'(WORDS_PER_PKT);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  typedef enum logic {FILL, SEND} state_t;

  state_t                                r_state;
  logic [CW-1:0]                         r_lane_cnt;
  logic [CW-1:0]                         r_word_cnt;
  logic                                  r_pend;
  logic                                  r_first_beat;
  logic [LANES-1:0][FP_DATA_WIDTH-1:0]   r_tdata;
  logic [KW-1:0]                         r_tkeep;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]       r_tuser;
  logic                                  r_tvalid;
  logic                                  r_tlast;
  logic                                  r_pkt_sent;

  logic [CW-1:0]                         w_pend_x;
  logic [CW-1:0]                         w_rem;
  logic [CW-1:0]                         w_target;
  logic [CW-1:0]                         w_lane_nxt;
  logic [CW-1:0]                         w_word_nxt;
  logic [CW-1:0]                         w_len;
  logic [15:0]                           w_bytes;
  logic                                  w_rd_en;
  logic                                  w_beat_done;
  logic                                  w_flush;
  logic                                  w_emit;
  logic                                  w_last;
  logic [KW-1:0]                         w_keep;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]       w_tuser;

  // Lane and word counters advance together, so word_cnt-lane_cnt is the word count at beat start.
  assign w_pend_x   = {{(CW-1){1'b0}}, r_pend};
  assign w_rem      = WPP_C - r_word_cnt + r_lane_cnt;
  assign w_target   = (w_rem < LANES_C) ? w_rem : LANES_C;
  assign w_lane_nxt = r_lane_cnt + w_pend_x;
  assign w_word_nxt = r_word_cnt + w_pend_x;

  assign w_rd_en = !srst && (r_state == FILL) && !fifo_empty &&
                   (w_lane_nxt < w_target) && (w_word_nxt < WPP_C);

  // The beat closes on the edge that captures its final word.
  assign w_beat_done = (r_state == FILL) && r_pend && (w_lane_nxt == w_target);

`ifdef FP_PACKER_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  logic [IW-1:0] r_idle;
  logic          w_idle_cond;

  assign w_idle_cond = (r_state == FILL) && fifo_empty && !r_pend && (r_word_cnt != '0);
  assign w_flush     = w_idle_cond && (r_idle == IW'(FLUSH_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (srst || w_rd_en || (r_state != FILL) || w_flush)
      r_idle <= '0;
    else if (w_idle_cond)
      r_idle <= r_idle + 1'b1;
  end
`else
  assign w_flush = 1'b0;
`endif

  assign w_emit  = w_beat_done || w_flush;
  assign w_last  = (w_word_nxt == WPP_C) || w_flush;
  assign w_len   = w_flush ? w_word_nxt : WPP_C;
  assign w_bytes = 16'(w_len) * 16'(BPL);

  always_comb begin
    w_keep = '0;
    for (int l = 0; l < LANES; l++)
      if (CW'(l) < w_lane_nxt) w_keep[l*BPL +: BPL] = '1;
  end

  always_comb begin
    w_tuser = '0;
    if (r_first_beat) begin
      w_tuser[15:0]  = w_bytes;
      w_tuser[31:24] = DST_PORT;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state      <= FILL;
      r_lane_cnt   <= '0;
      r_word_cnt   <= '0;
      r_pend       <= 1'b0;
      r_first_beat <= 1'b1;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tuser      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_pkt_sent   <= 1'b0;
    end else begin
      r_pend     <= w_rd_en;
      r_pkt_sent <= 1'b0;
      case (r_state)
        FILL: begin
          if (r_pend) begin
            r_tdata[r_lane_cnt[LIW-1:0]] <= fifo_dout;
            r_lane_cnt <= w_lane_nxt;
            r_word_cnt <= w_word_nxt;
          end
          if (w_emit) begin
            r_state  <= SEND;
            r_tvalid <= 1'b1;
            r_tkeep  <= w_keep;
            r_tlast  <= w_last;
            r_tuser  <= w_tuser;
          end
        end
        SEND: begin
          if (M_AXIS_tready) begin
            r_state    <= FILL;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tkeep    <= '0;
            r_tuser    <= '0;
            r_tdata    <= '0;
            r_lane_cnt <= '0;
            if (r_tlast) begin
              r_word_cnt   <= '0;
              r_first_beat <= 1'b1;
              r_pkt_sent   <= 1'b1;
            end else begin
              r_first_beat <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tkeep  = r_tkeep;
  assign M_AXIS_tuser  = r_tuser;
  assign M_AXIS_tvalid = r_tvalid;
  assign M_AXIS_tlast  = r_tlast;
  assign pkt_sent      = r_pkt_sent;
endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench: two packers (16- and 10-word packets) fed from queue FIFO models.
module tb_fp_result_packer;
  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic         srst0, srst1;
  logic [31:0]  dout0 = '0, dout1 = '0;
  logic         emp0 = 1'b1, emp1 = 1'b1;
  logic         rd0, rd1;
  logic [255:0] td0, td1;
  logic [31:0]  tk0, tk1;
  logic [127:0] tu0, tu1;
  logic         tv0, tv1, tl0, tl1, ps0, ps1;
  logic         tr0 = 1'b1, tr1 = 1'b1;
  int           mode0 = 1, mode1 = 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] fq0[$], fq1[$];
  int          rdc0 = 0, rdc1 = 0;
  beat_t       exp0[$], exp1[$];

  logic [31:0] bb[2][8];
  int          bn[2], pw[2];
  bit          first[2];
  bit          psx0 = 0, psx1 = 0;

  fp_result_packer #(.WORDS_PER_PKT(16)) u_dut0 (
    .aclk(aclk), .srst(srst0), .fifo_dout(dout0), .fifo_empty(emp0), .fifo_rd_en(rd0),
    .M_AXIS_tdata(td0), .M_AXIS_tkeep(tk0), .M_AXIS_tuser(tu0), .M_AXIS_tvalid(tv0),
    .M_AXIS_tready(tr0), .M_AXIS_tlast(tl0), .pkt_sent(ps0));

  fp_result_packer #(.WORDS_PER_PKT(10)) u_dut1 (
    .aclk(aclk), .srst(srst1), .fifo_dout(dout1), .fifo_empty(emp1), .fifo_rd_en(rd1),
    .M_AXIS_tdata(td1), .M_AXIS_tkeep(tk1), .M_AXIS_tuser(tu1), .M_AXIS_tvalid(tv1),
    .M_AXIS_tready(tr1), .M_AXIS_tlast(tl1), .pkt_sent(ps1));

  // Standard-mode FIFO: data appears the cycle after the read; writes show up one edge later.
  always @(posedge aclk) begin
    if (rd0 && fq0.size() > 0) begin
      dout0 <= fq0.pop_front();
      rdc0  <= rdc0 + 1;
    end
    emp0 <= (fq0.size() == 0);
    if (rd1 && fq1.size() > 0) begin
      dout1 <= fq1.pop_front();
      rdc1  <= rdc1 + 1;
    end
    emp1 <= (fq1.size() == 0);
  end

  // mode: 0 random backpressure, 1 always ready, 2 stalled
  initial forever begin
    @(posedge aclk); #1;
    tr0 = (mode0 == 1) ? 1'b1 : (mode0 == 2) ? 1'b0 : (($urandom % 4) != 0);
    tr1 = (mode1 == 1) ? 1'b1 : (mode1 == 2) ? 1'b0 : (($urandom % 4) != 0);
  end

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, ex);
    end
  endtask

  function automatic int wpp(input int k);
    return (k == 0) ? 16 : 10;
  endfunction

  // Reference model: a packet is wpp words; beats hold up to 8 words; first beat carries length.
  task automatic emit(input int k, input bit last, input int bytes);
    beat_t b;
    b.d = '0; b.k = '0; b.u = '0; b.l = last;
    for (int i = 0; i < bn[k]; i++) b.d[i*32 +: 32] = bb[k][i];
    for (int i = 0; i < bn[k] * 4; i++) b.k[i] = 1'b1;
    if (first[k]) begin
      b.u[15:0]  = 16'(bytes);
      b.u[31:24] = 8'h01;
    end
    if (k == 0) exp0.push_back(b); else exp1.push_back(b);
    first[k] = last;
    bn[k] = 0;
    if (last) pw[k] = 0;
  endtask

  task automatic model_add(input int k, input logic [31:0] w);
    bb[k][bn[k]] = w;
    bn[k]++;
    pw[k]++;
    if (pw[k] == wpp(k))  emit(k, 1'b1, 4 * wpp(k));
    else if (bn[k] == 8)  emit(k, 1'b0, 4 * wpp(k));
  endtask

  task automatic model_reset(input int k);
    bn[k] = 0; pw[k] = 0; first[k] = 1'b1;
  endtask

  task automatic push(input int k, input logic [31:0] w);
    if (k == 0) fq0.push_back(w); else fq1.push_back(w);
    model_add(k, w);
  endtask

  task automatic check_beat(input int k, input beat_t a);
    beat_t e;
    bit    has;
    has = 0;
    if (k == 0) begin if (exp0.size() > 0) begin e = exp0.pop_front(); has = 1; end end
    else        begin if (exp1.size() > 0) begin e = exp1.pop_front(); has = 1; end end
    if (!has) begin
      total++; bad++;
      $display("FAIL beat%0d_unexpected act_tdata=%h exp=none", k, a.d);
    end else begin
      cmp($sformatf("tdata%0d", k), a.d, e.d);
      cmp($sformatf("tkeep%0d", k), 256'(a.k), 256'(e.k));
      cmp($sformatf("tuser%0d", k), 256'(a.u), 256'(e.u));
      cmp($sformatf("tlast%0d", k), 256'(a.l), 256'(e.l));
    end
  endtask

  // Monitors: sample mid-cycle, a handshake happens on the next rising edge.
  always @(negedge aclk) begin
    beat_t a;
    if (srst0) psx0 = 0;
    else begin
      if (psx0 || ps0) cmp("pkt_sent0", 256'(ps0), 256'(psx0));
      psx0 = tv0 && tr0 && tl0;
      if (tv0 && tr0) begin
        a.d = td0; a.k = tk0; a.u = tu0; a.l = tl0;
        check_beat(0, a);
      end
    end
  end

  always @(negedge aclk) begin
    beat_t a;
    if (srst1) psx1 = 0;
    else begin
      if (psx1 || ps1) cmp("pkt_sent1", 256'(ps1), 256'(psx1));
      psx1 = tv1 && tr1 && tl1;
      if (tv1 && tr1) begin
        a.d = td1; a.k = tk1; a.u = tu1; a.l = tl1;
        check_beat(1, a);
      end
    end
  end

  task automatic drain(input int k, input int budget);
    int n;
    n = 0;
    while (((k == 0) ? exp0.size() : exp1.size()) != 0 && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL drain%0d_timeout act_pending=%0d exp=0", k, (k == 0) ? exp0.size() : exp1.size());
    end
  endtask

  initial begin
    logic [255:0] s_d;
    logic [31:0]  s_k;
    logic [127:0] s_u;
    int           n, base;

    for (int k = 0; k < 2; k++) model_reset(k);
    srst0 = 1'b1; srst1 = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    cmp("rst_rd_en",  256'(rd0), 256'(0));
    cmp("rst_tvalid", 256'(tv0), 256'(0));
    cmp("rst_tlast",  256'(tl0), 256'(0));
    cmp("rst_pkt",    256'(ps0), 256'(0));
    cmp("rst_tdata",  td0, 256'(0));
    cmp("rst_tkeep",  256'(tk0), 256'(0));
    cmp("rst_tuser",  256'(tu0), 256'(0));
    cmp("rst_tvalid1", 256'(tv1), 256'(0));
    @(posedge aclk); #1;
    srst0 = 1'b0; srst1 = 1'b0;

    // two full beats, back to back
    for (int i = 0; i < 16; i++) push(0, 32'h3F800000 + i);
    drain(0, 200);

    // 10-word packet: second beat is a 2-lane tail
    for (int i = 0; i < 10; i++) push(1, 32'h3F800000 + i);
    drain(1, 200);

    // downstream stall with a valid beat held
    mode0 = 2;
    for (int i = 0; i < 8; i++) push(0, 32'h40000000 + i);
    n = 0;
    do begin @(negedge aclk); n++; end while (!tv0 && n < 100);
    cmp("hold_tvalid_rise", 256'(tv0), 256'(1));
    for (int i = 8; i < 16; i++) push(0, 32'h40000000 + i);
    @(negedge aclk);
    s_d = td0; s_k = tk0; s_u = tu0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      cmp("hold_stable", {td0 ^ s_d}, 256'(0));
      cmp("hold_ku", 256'({tk0, tu0}), 256'({s_k, s_u}));
      cmp("hold_rd_en", 256'(rd0), 256'(0));
    end
    @(posedge aclk); #1;
    mode0 = 1;
    drain(0, 200);

    // 5-cycle gaps between words
    for (int i = 0; i < 16; i++) begin
      push(0, 32'h41000000 + i);
      repeat (5) @(posedge aclk);
      #1;
    end
    drain(0, 200);

    // reset with 3 words captured and the 4th in flight
    base = rdc0;
    for (int i = 0; i < 4; i++) push(0, 32'hDEAD0000 + i);
    n = 0;
    while (rdc0 != base + 4 && n < 50) begin @(posedge aclk); #1; n++; end
    cmp("srst_reads", 256'(rdc0 - base), 256'(4));
    srst0 = 1'b1;
    @(posedge aclk); #1;
    srst0 = 1'b0;
    model_reset(0);
    @(negedge aclk);
    cmp("srst_tvalid", 256'(tv0), 256'(0));
    cmp("srst_tkeep",  256'(tk0), 256'(0));
    @(posedge aclk); #1;
    for (int i = 0; i < 16; i++) push(0, 32'h42000000 + i);
    drain(0, 200);

`ifdef FP_PACKER_FLUSH_EN
    // idle timeout closes a 3-word packet
    for (int i = 0; i < 3; i++) push(0, 32'h43000000 + i);
    emit(0, 1'b1, 4 * pw[0]);
    drain(0, 300);
`else
    // a partial packet must wait for more data
    for (int i = 0; i < 3; i++) push(0, 32'h43000000 + i);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (tv0) n++;
    end
    cmp("partial_no_emit", 256'(n), 256'(0));
    @(posedge aclk); #1;
    for (int i = 3; i < 16; i++) push(0, 32'h43000000 + i);
    drain(0, 200);
`endif

    // random data, random gaps and random backpressure on both packers
    mode0 = 0; mode1 = 0;
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 2; k++)
        for (int w = 0; w < wpp(k); w++) begin
          push(k, $urandom);
          if (($urandom % 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge aclk);
            #1;
          end
        end
    drain(0, 3000);
    drain(1, 3000);
    mode0 = 1; mode1 = 1;
    repeat (4) @(posedge aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
